branch_predictor_unit: RTL and testbench

BRANCH_PREDICTOR_UNIT -- requirements
Module: branch_predictor_unit

---
 rtl/branch_predictor_unit.sv | 176 +++++++++++++++++
 tb/tb_branch_predictor_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_unit.sv
// Branch predictor: set-associative BTB plus a table of saturating direction
// counters. Supports static not-taken, bimodal and gshare indexing.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stats_clr           synchronous clear of the statistics counters
//   pc_if               fetch PC; pred_taken/pred_target are combinational from it
//   upd_*               resolved conditional branch from EX
//   mispredict          combinational flush request for the resolved branch
//   redirect_pc         correct next PC of the resolved branch
//   stat_total          resolved branch count
//   stat_correct        correctly predicted branch count
module branch_predictor_unit #(
  parameter int unsigned BTB_SETS    = 64,
  parameter int unsigned BTB_WAYS    = 2,
  parameter int unsigned BHT_ENTRIES = 4096,
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned GHR_WIDTH   = 8,
  parameter int unsigned MODE        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stats_clr,
  input  logic [31:0] pc_if,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [63:0] stat_total,
  output logic [63:0] stat_correct
);

  localparam int unsigned SET_W = $clog2(BTB_SETS);
  localparam int unsigned TAG_W = 32 - SET_W - 2;
  localparam int unsigned BHT_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  // History only participates in the index for gshare.
  localparam logic [BHT_W-1:0] HIST_MASK = (MODE == 2) ? '1 : '0;

  // Storage
  logic [BTB_WAYS-1:0]  btb_valid  [BTB_SETS];
  logic [TAG_W-1:0]     btb_tag    [BTB_SETS][BTB_WAYS];
  logic [31:0]          btb_target [BTB_SETS][BTB_WAYS];
  logic                 btb_lru    [BTB_SETS];
  logic [CTR_WIDTH-1:0] bht        [BHT_ENTRIES];
  logic [GHR_WIDTH-1:0] ghr;

  function automatic logic [BHT_W-1:0] bht_index(input logic [31:0] pc,
                                                 input logic [GHR_WIDTH-1:0] hist);
    return pc[BHT_W+1:2] ^ (BHT_W'(hist) & HIST_MASK);
  endfunction

  // Lookup side (fetch)
  logic [SET_W-1:0]     lk_set;
  logic [TAG_W-1:0]     lk_tag;
  logic [BTB_WAYS-1:0]  lk_match;
  logic                 lk_way;
  logic                 lk_hit;
  logic [CTR_WIDTH-1:0] lk_ctr;

  // Update side (resolve)
  logic [SET_W-1:0]     up_set;
  logic [TAG_W-1:0]     up_tag;
  logic [BTB_WAYS-1:0]  up_match;
  logic                 up_hit;
  logic                 up_way;
  logic [BHT_W-1:0]     up_idx;
  logic [CTR_WIDTH-1:0] up_ctr;
  logic [CTR_WIDTH-1:0] up_ctr_next;

  assign lk_set = pc_if[SET_W+1:2];
  assign lk_tag = pc_if[31:SET_W+2];
  assign up_set = upd_pc[SET_W+1:2];
  assign up_tag = upd_pc[31:SET_W+2];

  for (genvar g = 0; g < BTB_WAYS; g++) begin : g_way
    assign lk_match[g] = btb_valid[lk_set][g] && (btb_tag[lk_set][g] == lk_tag);
    assign up_match[g] = btb_valid[up_set][g] && (btb_tag[up_set][g] == up_tag);
  end

  assign lk_hit = |lk_match;
  assign lk_way = (BTB_WAYS == 2) ? lk_match[BTB_WAYS-1] : 1'b0;
  assign lk_ctr = bht[bht_index(pc_if, ghr)];

  // Prediction: taken only on a BTB hit with a counter leaning taken.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_if + 32'd4;
    if ((MODE != 0) && lk_hit && lk_ctr[CTR_WIDTH-1]) begin
      pred_taken  = 1'b1;
      pred_target = btb_target[lk_set][lk_way];
    end
  end

  assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                     (upd_taken && (upd_pred_target != upd_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  assign up_hit = |up_match;
  assign up_idx = bht_index(upd_pc, ghr);
  assign up_ctr = bht[up_idx];

  // Way choice for a taken resolve: matching way, else first invalid, else LRU.
  always_comb begin
    up_way = 1'b0;
    if (BTB_WAYS == 2) begin
      if (up_hit)                               up_way = up_match[BTB_WAYS-1];
      else if (!btb_valid[up_set][0])           up_way = 1'b0;
      else if (!btb_valid[up_set][BTB_WAYS-1])  up_way = 1'b1;
      else                                      up_way = btb_lru[up_set];
    end
  end

  // Saturating counter step.
  always_comb begin
    up_ctr_next = up_ctr;
    if (upd_taken) begin
      if (up_ctr != CTR_MAX) up_ctr_next = up_ctr + CTR_WIDTH'(1);
    end else begin
      if (up_ctr != '0) up_ctr_next = up_ctr - CTR_WIDTH'(1);
    end
  end

  // Direction counters and global history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[BHT_W'(i)] <= CTR_INIT;
      ghr <= '0;
    end else if (upd_valid) begin
      bht[up_idx] <= up_ctr_next;
      ghr         <= GHR_WIDTH'({ghr, upd_taken});
    end
  end

  // BTB valid bits and replacement state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < BTB_SETS; s++) begin
        btb_valid[SET_W'(s)] <= '0;
        btb_lru[SET_W'(s)]   <= 1'b0;
      end
    end else if (upd_valid && upd_taken) begin
      btb_valid[up_set][up_way] <= 1'b1;
      btb_lru[up_set]           <= ~up_way;
    end
  end

  // BTB payload; qualified by the valid bits so it needs no reset.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btb_tag[up_set][up_way]    <= up_tag;
      btb_target[up_set][up_way] <= upd_target;
    end
  end

  // Statistics; clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_total   <= '0;
      stat_correct <= '0;
    end else if (stats_clr) begin
      stat_total   <= '0;
      stat_correct <= '0;
    end else if (upd_valid) begin
      stat_total <= stat_total + 64'd1;
      if (!mispredict) stat_correct <= stat_correct + 64'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Self-checking bench for branch_predictor_unit: directed scenarios plus
// randomized traffic compared against a table-based reference model.
module tb_branch_predictor_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stats_clr = 1'b0;
  logic [31:0] pc_if = 32'h0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = 32'h0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [63:0] stat_total;
  logic [63:0] stat_correct;

  // gshare instance: shares stimulus, carries its own prediction fields
  logic        g_upd_pred_taken = 1'b0;
  logic [31:0] g_upd_pred_target = 32'h0;
  logic        g_pred_taken;
  logic [31:0] g_pred_target;
  logic        g_mispredict;
  logic [31:0] g_redirect_pc;
  logic [63:0] g_stat_total;
  logic [63:0] g_stat_correct;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor_unit #(.BTB_SETS(64), .BTB_WAYS(2), .BHT_ENTRIES(4096),
                          .CTR_WIDTH(2), .GHR_WIDTH(8), .MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .stats_clr(stats_clr), .pc_if(pc_if),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .stat_total(stat_total), .stat_correct(stat_correct));

  branch_predictor_unit #(.BTB_SETS(64), .BTB_WAYS(2), .BHT_ENTRIES(4096),
                          .CTR_WIDTH(2), .GHR_WIDTH(8), .MODE(2)) dut_g (
    .clk(clk), .rst_n(rst_n), .stats_clr(stats_clr), .pc_if(pc_if),
    .pred_taken(g_pred_taken), .pred_target(g_pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(g_upd_pred_taken),
    .upd_pred_target(g_upd_pred_target), .mispredict(g_mispredict),
    .redirect_pc(g_redirect_pc), .stat_total(g_stat_total), .stat_correct(g_stat_correct));

  // ---------------- reference model (bimodal, 64 sets x 2 ways) ----------------
  int          m_ctr    [int];   // direction counter per pc word, absent = 1
  bit          m_valid  [int];   // key = set*2 + way
  int          m_tag    [int];
  logic [31:0] m_tgt    [int];
  int          m_victim [int];   // way replaced next when the set is full
  longint unsigned m_total, m_correct;

  function automatic void m_reset();
    m_ctr.delete(); m_valid.delete(); m_tag.delete(); m_tgt.delete(); m_victim.delete();
    m_total = 0; m_correct = 0;
  endfunction

  function automatic int m_set(logic [31:0] pc);  return int'((pc >> 2) % 64);  endfunction
  function automatic int m_tagof(logic [31:0] pc); return int'(pc >> 8);       endfunction
  function automatic int m_bidx(logic [31:0] pc); return int'((pc >> 2) % 4096); endfunction
  function automatic int m_getctr(int i); return m_ctr.exists(i) ? m_ctr[i] : 1; endfunction
  function automatic bit m_isvalid(int k); return m_valid.exists(k) && m_valid[k]; endfunction

  function automatic int m_find(logic [31:0] pc);
    for (int w = 0; w < 2; w++)
      if (m_isvalid(m_set(pc) * 2 + w) && m_tag[m_set(pc) * 2 + w] == m_tagof(pc)) return w;
    return -1;
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int w = m_find(pc);
    t  = (w >= 0) && (m_getctr(m_bidx(pc)) >= 2);
    tg = t ? m_tgt[m_set(pc) * 2 + w] : pc + 32'd4;
  endfunction

  function automatic bit m_misp(bit v, bit t, logic [31:0] tg, bit pt, logic [31:0] ptg);
    return v && ((t != pt) || (t && ptg != tg));
  endfunction

  function automatic void m_update(bit v, logic [31:0] pc, bit t, logic [31:0] tg,
                                   bit pt, logic [31:0] ptg, bit clr);
    int s, w, c;
    if (clr) begin m_total = 0; m_correct = 0; end
    else if (v) begin
      m_total++;
      if (!m_misp(v, t, tg, pt, ptg)) m_correct++;
    end
    if (!v) return;
    c = m_getctr(m_bidx(pc));
    m_ctr[m_bidx(pc)] = t ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
    if (!t) return;
    s = m_set(pc);
    w = m_find(pc);
    if (w < 0) begin
      if (!m_isvalid(s * 2))          w = 0;
      else if (!m_isvalid(s * 2 + 1)) w = 1;
      else                            w = m_victim.exists(s) ? m_victim[s] : 0;
    end
    m_valid[s * 2 + w] = 1'b1;
    m_tag[s * 2 + w]   = m_tagof(pc);
    m_tgt[s * 2 + w]   = tg;
    m_victim[s]        = 1 - w;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    if (rst_n) m_update(upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
                        upd_pred_target, stats_clr);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    stats_clr = 1'b0;
  endtask

  task automatic do_reset();
    upd_valid = 1'b0; stats_clr = 1'b0;
    rst_n = 1'b0;
    #2;
    m_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Resolve a branch carrying the model's own prediction down the pipe.
  task automatic resolve(logic [31:0] pc, bit t, logic [31:0] tg);
    bit pt; logic [31:0] ptg;
    m_predict(pc, pt, ptg);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tg;
    upd_pred_taken = pt; upd_pred_target = ptg;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pc_if = $urandom;
      #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== pc_if + 32'd4) begin
        errors++;
        $display("FAIL reset_pred pc=%h got taken=%b tgt=%h want 0/%h", pc_if, pred_taken,
                 pred_target, pc_if + 32'd4);
      end
    end
    checks++;
    if (stat_total !== 64'd0 || stat_correct !== 64'd0 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL reset_stats got total=%0d correct=%0d misp=%b want 0/0/0",
               stat_total, stat_correct, mispredict);
    end
  endtask

  task automatic test_first_branch();
    do_reset();
    pc_if = 32'h100;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL first_pred got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h80;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h104;
    #1;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
      errors++;
      $display("FAIL first_resolve got misp=%b redirect=%h want 1/00000080", mispredict, redirect_pc);
    end
    tick();
    checks++;
    if (stat_total !== 64'd1 || stat_correct !== 64'd0) begin
      errors++;
      $display("FAIL first_stats got %0d/%0d want 1/0", stat_total, stat_correct);
    end
  endtask

  task automatic test_bimodal();
    bit          exp_t  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_tg [4] = '{32'h204, 32'h40, 32'h40, 32'h204};
    bit          dir    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    pc_if = 32'h200;
    // checks after 1 taken(counter 10), 2 taken(11), +1 not-taken(10), +2 not-taken(01)
    for (int i = 0; i < 4; i++) begin
      resolve(32'h200, dir[i], 32'h40);
      if (i == 0) continue;
      #1;
      checks++;
      if (pred_taken !== exp_t[i] || pred_target !== exp_tg[i]) begin
        errors++;
        $display("FAIL bimodal_step%0d got %b/%h want %b/%h", i, pred_taken, pred_target,
                 exp_t[i], exp_tg[i]);
      end
    end
  endtask

  task automatic test_btb_lru();
    logic [31:0] pcs  [6] = '{32'h100, 32'h200, 32'h300, 32'h300, 32'h200, 32'h400};
    bit          hit  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    resolve(32'h100, 1'b1, 32'h1100);
    resolve(32'h200, 1'b1, 32'h1200);
    resolve(32'h300, 1'b1, 32'h1300);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        resolve(32'h200, 1'b1, 32'h1200);
        resolve(32'h400, 1'b1, 32'h1400);
      end
      pc_if = pcs[i];
      #1;
      checks++;
      if (pred_taken !== hit[i] ||
          pred_target !== (hit[i] ? pcs[i] + 32'h1000 : pcs[i] + 32'd4)) begin
        errors++;
        $display("FAIL btb_lru pc=%h got %b/%h want hit=%b", pcs[i], pred_taken, pred_target, hit[i]);
      end
    end
  endtask

  task automatic test_target_and_clear();
    do_reset();
    resolve(32'h600, 1'b1, 32'h60);
    pc_if = 32'h600;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h60) begin
      errors++;
      $display("FAIL tgt_learn got %b/%h want 1/00000060", pred_taken, pred_target);
    end
    upd_valid = 1'b0; upd_pc = 32'h600; upd_taken = 1'b1; upd_target = 32'h70;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h60;
    #1;
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL misp_gated got %b want 0", mispredict);
    end
    upd_valid = 1'b1; upd_pred_taken = 1'b1;
    #1;
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h70) begin
      errors++;
      $display("FAIL wrong_target got misp=%b redirect=%h want 1/00000070", mispredict, redirect_pc);
    end
    tick();
    checks++;
    if (stat_total !== 64'd2 || stat_correct !== 64'd0) begin
      errors++;
      $display("FAIL tgt_stats got %0d/%0d want 2/0", stat_total, stat_correct);
    end
    upd_valid = 1'b1; upd_pc = 32'h900; upd_taken = 1'b0;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h904;
    stats_clr = 1'b1;
    tick();
    checks++;
    if (stat_total !== 64'd0 || stat_correct !== 64'd0) begin
      errors++;
      $display("FAIL stats_clr got %0d/%0d want 0/0", stat_total, stat_correct);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    bit mt; logic [31:0] mtg;
    for (int i = 0; i < 6; i++) pool[i] = 32'((((i % 3) + 1) << 8) | (((i / 3) * 2 + 3) << 2));
    do_reset();
    for (int n = 0; n < 400; n++) begin
      pc_if = ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 5)];
      upd_valid = ($urandom_range(0, 9) < 7);
      upd_pc = pool[$urandom_range(0, 5)];
      upd_taken = $urandom_range(0, 1) == 1;
      upd_target = 32'h4000 + 32'($urandom_range(0, 3)) * 32'h10;
      m_predict(upd_pc, mt, mtg);
      if ($urandom_range(0, 3) != 0) begin
        upd_pred_taken = mt; upd_pred_target = mtg;
      end else begin
        upd_pred_taken = $urandom_range(0, 1) == 1;
        upd_pred_target = 32'h4000 + 32'($urandom_range(0, 3)) * 32'h10;
      end
      stats_clr = ($urandom_range(0, 39) == 0);
      #1;
      m_predict(pc_if, mt, mtg);
      checks++;
      if (pred_taken !== mt || pred_target !== mtg) begin
        errors++;
        $display("FAIL rand_pred n=%0d pc=%h got %b/%h want %b/%h", n, pc_if, pred_taken,
                 pred_target, mt, mtg);
      end
      checks++;
      if (mispredict !== m_misp(upd_valid, upd_taken, upd_target, upd_pred_taken, upd_pred_target) ||
          redirect_pc !== (upd_taken ? upd_target : upd_pc + 32'd4)) begin
        errors++;
        $display("FAIL rand_resolve n=%0d got misp=%b redirect=%h", n, mispredict, redirect_pc);
      end
      tick();
      checks++;
      if (stat_total !== m_total || stat_correct !== m_correct) begin
        errors++;
        $display("FAIL rand_stats n=%0d got %0d/%0d want %0d/%0d", n, stat_total, stat_correct,
                 m_total, m_correct);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    resolve(32'h700, 1'b1, 32'h90);
    pc_if = 32'h700;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h90) begin
      errors++;
      $display("FAIL areset_learn got %b/%h want 1/00000090", pred_taken, pred_target);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h704 || stat_total !== 64'd0) begin
      errors++;
      $display("FAIL areset_now got %b/%h total=%0d want 0/00000704/0", pred_taken, pred_target,
               stat_total);
    end
    m_reset();
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h704) begin
      errors++;
      $display("FAIL areset_after got %b/%h want 0/00000704", pred_taken, pred_target);
    end
  endtask

  task automatic test_gshare();
    longint unsigned prev;
    do_reset();
    pc_if = 32'h500;
    for (int r = 1; r <= 20; r++) begin
      #1;
      upd_valid = 1'b1; upd_pc = 32'h500; upd_taken = (r % 2) == 1; upd_target = 32'h40;
      upd_pred_taken = pred_taken;     upd_pred_target = pred_target;
      g_upd_pred_taken = g_pred_taken; g_upd_pred_target = g_pred_target;
      prev = g_stat_correct;
      tick();
      if (r >= 13) begin
        checks++;
        if (g_stat_correct !== prev + 1) begin
          errors++;
          $display("FAIL gshare_learned r=%0d got %0d want %0d", r, g_stat_correct, prev + 1);
        end
      end
    end
    checks++;
    if (stat_total !== 64'd20 || stat_correct !== m_correct || stat_total - stat_correct < 64'd10) begin
      errors++;
      $display("FAIL bimodal_alternating got %0d/%0d want 20 total, correct=%0d (<=10)",
               stat_total, stat_correct, m_correct);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_branch();
    test_bimodal();
    test_btb_lru();
    test_target_and_clear();
    test_random();
    test_async_reset();
    test_gshare();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
